program_loader: RTL and testbench

Writes programs into the processor's instruction memory. It receives a byte stream over a valid/ready interface, assembles 32-bit instruction words in MSB-first order, and writes them to consecutive instruction-memory addresses starting at 0. The processor is held in reset for the whole load and released only after the checksum passes. It sits between the host byte link and the write port of the instruction memory that the processor core reads.

---
 rtl/program_loader_if.sv | 42 ++++
 rtl/program_loader.sv | 192 +++++++++++++++++++
 tb/tb_program_loader.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if
//   Groups the two bus-style links of the program loader:
//     - host byte stream (valid/ready):
//         rx_data_i, rx_valid_i   host -> loader
//         rx_ready_o              loader -> host
//     - instruction-memory write port:
//         imem_we_o, imem_addr_o, imem_wdata_o   loader -> memory
//   Handshake: a byte moves on every rising clock edge where rx_valid_i and
//   rx_ready_o are both 1. Once the host raises rx_valid_i it holds
//   rx_data_i stable until that edge. rx_ready_o never depends on
//   rx_valid_i.
//   Modports:
//     slave  - the loader side (consumes bytes, drives the memory port)
//     master - the host / environment side
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;

    modport slave (
        input  rx_data_i,
        input  rx_valid_i,
        output rx_ready_o,
        output imem_we_o,
        output imem_addr_o,
        output imem_wdata_o
    );

    modport master (
        output rx_data_i,
        output rx_valid_i,
        input  rx_ready_o,
        input  imem_we_o,
        input  imem_addr_o,
        input  imem_wdata_o
    );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Receives a framed byte stream and writes the enclosed program into
//   instruction memory, starting at word address 0.
//   Frame: SYNC_BYTE, L (word count), 4*L data bytes (MSB first), C (XOR of
//   all data bytes). The processor is held in reset while loading and is
//   released only when the checksum matches.
//   Ports:
//     clk_i        clock, rising edge
//     reset        synchronous reset, active low
//     start_i      load request (honoured in IDLE, DONE, ERR)
//     bus          byte stream in, instruction-memory write port out
//     cpu_reset_o  processor reset request, active high
//     busy_o       load in progress
//     done_o       last load succeeded (level)
//     err_o        last load failed (level)
//     dbg_state    current FSM state encoding, for observation only
module program_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             start_i,
    program_loader_if.slave  bus,
    output logic             cpu_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Largest accepted word count: bounded by the 8-bit length field and by
    // the number of addressable words.
    localparam logic [8:0] MAX_LEN = (ADDR_W >= 8) ? 9'd255 : 9'(1 << ADDR_W);

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] addr;
    logic [7:0]        words_left;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_word;   // first three bytes of the current word
    logic [7:0]        csum;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;

    logic busy_next;
    logic cpu_reset_next;
    logic done_next;
    logic err_next;

    logic xfer;
    logic word_done;

    // Ready is a pure state decode so it never combinationally follows valid.
    assign bus.rx_ready_o = (state == S_SYNC) || (state == S_LEN) ||
                            (state == S_DATA) || (state == S_CSUM);
    assign xfer      = bus.rx_valid_i && bus.rx_ready_o;
    assign word_done = (state == S_DATA) && xfer && (byte_cnt == 2'd3);

    assign bus.imem_we_o    = we_q;
    assign bus.imem_addr_o  = waddr_q;
    assign bus.imem_wdata_o = wdata_q;
    assign dbg_state        = state;

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        busy_next      = 1'b0;
        cpu_reset_next = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) state_next = S_SYNC;
            end
            S_SYNC: begin
                // Anything other than the marker is dropped while hunting.
                if (xfer && (bus.rx_data_i == SYNC_BYTE)) state_next = S_LEN;
            end
            S_LEN: begin
                if (xfer) begin
                    if ((bus.rx_data_i == 8'd0) || ({1'b0, bus.rx_data_i} > MAX_LEN)) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done && (words_left == 8'd1)) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (xfer) begin
                    state_next = (bus.rx_data_i == csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start_i) state_next = S_SYNC;
            end
            default: state_next = S_IDLE;
        endcase

        // Status outputs are registered versions of the decode of the next
        // state, so they change on the same edge as the state itself.
        case (state_next)
            S_SYNC, S_LEN, S_DATA, S_CSUM: begin
                busy_next      = 1'b1;
                cpu_reset_next = 1'b1;
            end
            S_DONE: done_next = 1'b1;
            S_ERR: begin
                err_next       = 1'b1;
                cpu_reset_next = 1'b1;   // keep a partial program from running
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            busy_o      <= 1'b0;
            cpu_reset_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            busy_o      <= busy_next;
            cpu_reset_o <= cpu_reset_next;
            done_o      <= done_next;
            err_o       <= err_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            addr       <= '0;
            words_left <= 8'd0;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
            csum       <= 8'd0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
        end else begin
            we_q <= 1'b0;

            if ((state == S_LEN) && xfer) begin
                addr       <= '0;
                words_left <= bus.rx_data_i;
                byte_cnt   <= 2'd0;
                csum       <= 8'd0;
            end

            if ((state == S_DATA) && xfer) begin
                asm_word <= {asm_word[15:0], bus.rx_data_i};
                csum     <= csum ^ bus.rx_data_i;
                byte_cnt <= byte_cnt + 2'd1;
            end

            // The write registers are separate from the assembly register,
            // so the next word can start arriving while this one is written.
            if (word_done) begin
                we_q       <= 1'b1;
                waddr_q    <= addr;
                wdata_q    <= {asm_word, bus.rx_data_i};
                addr       <= addr + 1'b1;
                words_left <= words_left - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic start2;

    logic cpu_reset, busy, done, err;
    logic [2:0] dbg;
    logic cpu_reset2, busy2, done2, err2;
    logic [2:0] dbg2;

    program_loader_if #(.ADDR_W(8)) bus ();
    program_loader_if #(.ADDR_W(2)) bus2 ();

    program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk_i       (clk),
        .reset       (reset),
        .start_i     (start),
        .bus         (bus.slave),
        .cpu_reset_o (cpu_reset),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .dbg_state   (dbg)
    );

    program_loader #(.ADDR_W(2), .SYNC_BYTE(8'hA5)) dut2 (
        .clk_i       (clk),
        .reset       (reset),
        .start_i     (start2),
        .bus         (bus2.slave),
        .cpu_reset_o (cpu_reset2),
        .busy_o      (busy2),
        .done_o      (done2),
        .err_o       (err2),
        .dbg_state   (dbg2)
    );

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd6;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [39:0] exp_q[$];     // {addr, data} of expected writes, in order
    int wr_cycles[$];
    int cycle = 0;
    int wr2_count = 0;
    logic [39:0] exp_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (bus.imem_we_o === 1'b1) begin
            wr_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("imem_write", {24'd0, bus.imem_addr_o, bus.imem_wdata_o}, {24'd0, exp_w});
            end
        end
        if (bus2.imem_we_o === 1'b1) wr2_count++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.rx_ready_o) break;
            n++;
            if (n > 50) begin
                check("rx_ready_timeout", 64'd0, 64'd1);
                bus.rx_valid_i = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        int n;
        n = 0;
        bus2.rx_data_i  = b;
        bus2.rx_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (bus2.rx_ready_o) break;
            n++;
            if (n > 50) begin
                check("rx_ready2_timeout", 64'd0, 64'd1);
                bus2.rx_valid_i = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // gap=1 drops rx_valid_i for one cycle after every byte
    task automatic send_frame(input logic [7:0] f[$], input bit gap);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (gap) begin
                bus.rx_valid_i = 1'b0;
                tick();
            end
        end
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_nominal();
        exp_q.push_back({8'd0, 32'h20000301});
        exp_q.push_back({8'd1, 32'h28000100});
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] nominal[$];
    logic [7:0] bad_csum[$];
    logic [7:0] full[$];
    logic [31:0] prog[15];
    logic [7:0] cx;
    int c0;

    initial begin
        nominal  = '{8'hA5, 8'h02, 8'h20, 8'h00, 8'h03, 8'h01, 8'h28, 8'h00, 8'h01, 8'h00, 8'h0B};
        bad_csum = '{8'hA5, 8'h02, 8'h20, 8'h00, 8'h03, 8'h01, 8'h28, 8'h00, 8'h01, 8'h00, 8'h0C};
        prog = '{32'h20000301, 32'h28000100, 32'h20200001, 32'h10410000, 32'h00621820,
                 32'h20210001, 32'h14E0FFFC, 32'h00000000, 32'hAC030010, 32'h8C040010,
                 32'h20840000, 32'h3C051234, 32'h34A55678, 32'h08000000, 32'h80100000};

        reset = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        bus.rx_valid_i  = 1'b0;
        bus.rx_data_i   = 8'h00;
        bus2.rx_valid_i = 1'b0;
        bus2.rx_data_i  = 8'h00;
        tick();
        tick();
        reset = 1'b1;

        // reset state
        check("rst_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_ready", {63'd0, bus.rx_ready_o}, 64'd0);
        check("rst_we", {63'd0, bus.imem_we_o}, 64'd0);

        // nominal load
        pulse_start();
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("start_ready", {63'd0, bus.rx_ready_o}, 64'd1);
        push_nominal();
        for (int i = 0; i < 10; i++) send_byte(nominal[i]);
        check("pre_csum_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        send_byte(nominal[10]);
        bus.rx_valid_i = 1'b0;
        check("nom_done", {63'd0, done}, 64'd1);
        check("nom_err", {63'd0, err}, 64'd0);
        check("nom_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        check("nom_busy", {63'd0, busy}, 64'd0);
        tick();
        check("nom_writes_left", exp_q.size(), 64'd0);

        // garbage then backpressured frame
        pulse_start();
        check("restart_done_cleared", {63'd0, done}, 64'd0);
        push_nominal();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_stays_sync", {61'd0, dbg}, {61'd0, ST_SYNC});
        send_frame(nominal, 1'b1);
        check("bp_done", {63'd0, done}, 64'd1);
        check("bp_err", {63'd0, err}, 64'd0);
        check("bp_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        check("bp_writes_left", exp_q.size(), 64'd0);

        // bad checksum, then recovery
        pulse_start();
        push_nominal();
        send_frame(bad_csum, 1'b0);
        check("badc_err", {63'd0, err}, 64'd1);
        check("badc_done", {63'd0, done}, 64'd0);
        check("badc_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("badc_writes_left", exp_q.size(), 64'd0);
        pulse_start();
        check("restart_err_cleared", {63'd0, err}, 64'd0);
        push_nominal();
        send_frame(nominal, 1'b0);
        check("recover_done", {63'd0, done}, 64'd1);
        check("recover_err", {63'd0, err}, 64'd0);

        // zero length
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        bus.rx_valid_i = 1'b0;
        check("len0_err", {63'd0, err}, 64'd1);
        check("len0_state", {61'd0, dbg}, {61'd0, ST_ERR});
        tick();

        // too long for a 4-word memory, then the largest legal length
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        send_byte2(8'hA5);
        send_byte2(8'h05);
        bus2.rx_valid_i = 1'b0;
        check("len5_err", {63'd0, err2}, 64'd1);
        check("len5_cpu_reset", {63'd0, cpu_reset2}, 64'd1);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        send_byte2(8'hA5);
        send_byte2(8'h04);
        bus2.rx_valid_i = 1'b0;
        check("len4_accepted", {61'd0, dbg2}, {61'd0, ST_DATA});
        check("len4_busy", {63'd0, busy2}, 64'd1);
        tick();
        check("len_err_no_writes", wr2_count, 64'd0);

        // full 15-word program, back to back
        full = '{8'hA5, 8'd15};
        cx = 8'h00;
        for (int w = 0; w < 15; w++) begin
            exp_q.push_back({w[7:0], prog[w]});
            for (int k = 3; k >= 0; k--) begin
                full.push_back(prog[w][k*8 +: 8]);
                cx = cx ^ prog[w][k*8 +: 8];
            end
        end
        full.push_back(cx);
        pulse_start();
        wr_cycles.delete();
        c0 = cycle;
        send_frame(full, 1'b0);
        check("full_cycles", cycle - c0, 64'd63);
        check("full_done", {63'd0, done}, 64'd1);
        check("full_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        tick();
        check("full_write_count", wr_cycles.size(), 64'd15);
        for (int i = 1; i < wr_cycles.size(); i++) begin
            check("full_write_spacing", wr_cycles[i] - wr_cycles[i-1], 64'd4);
        end
        check("full_writes_left", exp_q.size(), 64'd0);

        // reset in the middle of a load
        pulse_start();
        exp_q.push_back({8'd0, 32'h20000301});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h01);
        check("midrst_we_pulse", {63'd0, bus.imem_we_o}, 64'd1);
        bus.rx_data_i = 8'h28;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_state", {61'd0, dbg}, {61'd0, ST_IDLE});
        check("midrst_outputs", {59'd0, cpu_reset, busy, done, err, bus.imem_we_o}, 64'd0);
        check("midrst_ready", {63'd0, bus.rx_ready_o}, 64'd0);
        repeat (8) tick();
        bus.rx_valid_i = 1'b0;
        check("midrst_writes_left", exp_q.size(), 64'd0);

        // start pulsed during DATA is ignored
        pulse_start();
        push_nominal();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h00);
        start = 1'b1;
        send_byte(8'h03);
        start = 1'b0;
        check("start_in_data_state", {61'd0, dbg}, {61'd0, ST_DATA});
        for (int i = 5; i < 11; i++) send_byte(nominal[i]);
        bus.rx_valid_i = 1'b0;
        check("start_in_data_done", {63'd0, done}, 64'd1);
        tick();
        check("start_in_data_writes_left", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
